fill_line_sequencer: RTL and testbench
======================================

FILL_LINE_SEQUENCER -- requirements
Module: fill_line_sequencer
Interface
REQ-001 SHALL have parameter PILL_PERIOD, 100, cycles between dispensed pills (2..1023).
REQ-002 SHALL have parameter INDEX_CYCLES, 300, conveyor run cycles per bottle index (2..1023).
REQ-003 SHALL have parameter SETTLE_CYCLES, 50, bottle settle cycles before filling (2..1023).
REQ-004 SHALL have parameter REFILL_TIMEOUT, 1000, max PAUSE cycles under FILL_WATCHDOG_EN (2..1023).
REQ-005 SHALL have port clk_1khz  input  1  sole clock, rising edge.
REQ-006 SHALL have port switch_clr  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse, begin batch.
REQ-008 SHALL have port bottle_full  input  1  one-cycle pulse, current bottle reached target pills.
REQ-009 SHALL have port batch_done  input  1  level, sampled with bottle_full; last bottle.
REQ-010 SHALL have port emergncy_stop  input  1  active-high level, emergency stop.
REQ-011 SHALL have port hopper_empty  input  1  active-high level, hopper out of pills.
REQ-012 SHALL have port hopper_refill  input  1  one-cycle pulse, operator refilled hopper.
REQ-013 SHALL have port conveyor_jam  input  1  active-high level, conveyor jammed.
REQ-014 SHALL have port ack  input  1  one-cycle pulse, operator acknowledge.
REQ-015 SHALL have ports conveyor_on, gate_open, pill_tick, alarm  output  1 each; state_out  output  3; fault_code  output  2.
Function
REQ-016 SHALL encode states IDLE=0, INDEX=1, SETTLE=2, FILL=3, PAUSE=4, FINISH=5, FAULT=6 on state_out; 7 unreachable, recovers to IDLE.
REQ-017 SHALL evaluate events per cycle in priority: emergncy_stop > conveyor_jam > bottle_full > hopper_empty > hopper_refill > timer expiry.
REQ-018 SHALL go IDLE->INDEX on start, loading phase timer INDEX_CYCLES-1; conveyor_on=1 throughout INDEX.
REQ-019 SHALL go INDEX->SETTLE when phase timer is 0, loading SETTLE_CYCLES-1; SETTLE->FILL when 0, loading pill timer PILL_PERIOD-1.
REQ-020 SHALL hold gate_open=1 only in FILL; pill_tick SHALL pulse one cycle, one cycle after pill timer reaches 0 in FILL, timer reloading PILL_PERIOD-1.
REQ-021 SHALL, on bottle_full in FILL, go FINISH if batch_done=1 else INDEX (timer reloaded); same-cycle pill expiry produces no pill_tick.
REQ-022 SHALL go FILL->PAUSE on hopper_empty; PAUSE->FILL on hopper_refill with hopper_empty=0, pill timer reloaded PILL_PERIOD-1.
REQ-023 SHALL go to FAULT from any state on emergncy_stop (fault_code=1), and from INDEX/SETTLE/FILL/PAUSE on conveyor_jam (fault_code=2).
REQ-024 SHALL leave FAULT to IDLE only on ack while emergncy_stop=0 and conveyor_jam=0; fault_code cleared to 0 on exit.
REQ-025 SHALL leave FINISH to IDLE on ack; start ignored outside IDLE; bottle_full ignored outside FILL.
REQ-026 SHALL drive alarm = bit 7 of a free-running 9-bit counter (~3.9 Hz) in FAULT, 0 elsewhere; conveyor_on/gate_open SHALL be 0 in FAULT.
REQ-027 SHALL register all outputs; state_out reflects the new state one cycle after the causing event.
Reset
REQ-028 SHALL, on switch_clr low, asynchronously force state IDLE, both timers and the 9-bit counter 0, and every output 0.
REQ-029 SHALL, on reset mid-operation, abandon the batch; after release, only start leaves IDLE.
Configuration
REQ-030 SHALL, with FILL_WATCHDOG_EN defined, go PAUSE->FAULT with fault_code=3 after REFILL_TIMEOUT cycles in PAUSE; without it, PAUSE waits indefinitely and fault_code=3 never occurs.
Structure
REQ-031 SHALL take state encodings and fault codes (NONE=0, ESTOP=1, JAM=2, REFILL_TO=3) from shared package fill_line_pkg.
REQ-032 SHALL instantiate sub-module cycle_timer (10-bit loadable down-counter, zero flag, holds at 0) for phase and pill timers.
Verification (PILL_PERIOD=4, INDEX_CYCLES=5, SETTLE_CYCLES=2, REFILL_TIMEOUT=8)
REQ-033 SHALL check: start -> conveyor_on for 5 cycles, SETTLE 2 cycles, FILL with pill_tick every 4 cycles.
REQ-034 SHALL check: bottle_full with batch_done=0 -> INDEX, pill_tick suppressed; with batch_done=1 -> FINISH, ack -> IDLE.
REQ-035 SHALL check: hopper_empty in FILL -> PAUSE, gate_open=0; hopper_refill alone ignored while empty; refill after empty=0 -> FILL, next tick 4 cycles later.
REQ-036 SHALL check: emergncy_stop in FILL -> FAULT code 1, alarm toggling; ack while stop high ignored; ack after release -> IDLE, code 0.
REQ-037 SHALL check: conveyor_jam in INDEX -> code 2; with FILL_WATCHDOG_EN, 8 cycles in PAUSE -> code 3.
REQ-038 SHALL check: switch_clr low mid-FILL -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/fill_line_pkg.sv
// Shared state encodings, fault codes and timer helpers for the pill fill line.
package fill_line_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIndex  = 3'd1,
        StSettle = 3'd2,
        StFill   = 3'd3,
        StPause  = 3'd4,
        StFinish = 3'd5,
        StFault  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        FaultNone     = 2'd0,
        FaultEstop    = 2'd1,
        FaultJam      = 2'd2,
        FaultRefillTo = 2'd3
    } fault_e;

    localparam int unsigned TimerWidth    = 10;
    localparam int unsigned AlarmCntWidth = 9;
    localparam int unsigned AlarmBit      = 7;

    // A phase of N cycles loads N-1 and ends on the cycle the timer reads zero.
    function automatic logic [TimerWidth-1:0] reload_val(input int unsigned cycles);
        return TimerWidth'(cycles - 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that holds at zero and flags it combinationally.
module cycle_timer #(
    parameter int unsigned Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/fill_line_sequencer.sv
// Bottle fill line sequencer: index, settle, fill with timed pills, pause, fault handling.
// Define FILL_WATCHDOG_EN to fault out of PAUSE after REFILL_TIMEOUT cycles.
module fill_line_sequencer
    import fill_line_pkg::*;
#(
    parameter int unsigned PILL_PERIOD    = 100,
    parameter int unsigned INDEX_CYCLES   = 300,
    parameter int unsigned SETTLE_CYCLES  = 50,
    parameter int unsigned REFILL_TIMEOUT = 1000
) (
    input  logic       clk_1khz,
    input  logic       switch_clr,
    input  logic       start,
    input  logic       bottle_full,
    input  logic       batch_done,
    input  logic       emergncy_stop,
    input  logic       hopper_empty,
    input  logic       hopper_refill,
    input  logic       conveyor_jam,
    input  logic       ack,
    output logic       conveyor_on,
    output logic       gate_open,
    output logic       pill_tick,
    output logic       alarm,
    output logic [2:0] state_out,
    output logic [1:0] fault_code
);

    localparam logic [TimerWidth-1:0] IndexReload  = reload_val(INDEX_CYCLES);
    localparam logic [TimerWidth-1:0] SettleReload = reload_val(SETTLE_CYCLES);
    localparam logic [TimerWidth-1:0] PillReload   = reload_val(PILL_PERIOD);
    localparam logic [TimerWidth-1:0] RefillReload = reload_val(REFILL_TIMEOUT);

    state_e                   state_q, state_d;
    fault_e                   fault_q, fault_d;
    logic [AlarmCntWidth-1:0] alarm_cnt_q, alarm_cnt_d;
    logic                     conveyor_q, gate_q, tick_q, alarm_q, tick_d;
    logic                     ph_load, pill_load, ph_zero, pill_zero;
    logic [TimerWidth-1:0]    ph_val;

    cycle_timer #(.Width(TimerWidth)) u_phase_timer (
        .clk_i      (clk_1khz),
        .rst_ni     (switch_clr),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .zero_o     (ph_zero)
    );

    cycle_timer #(.Width(TimerWidth)) u_pill_timer (
        .clk_i      (clk_1khz),
        .rst_ni     (switch_clr),
        .load_i     (pill_load),
        .load_val_i (PillReload),
        .zero_o     (pill_zero)
    );

    assign alarm_cnt_d = alarm_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        tick_d    = 1'b0;
        ph_load   = 1'b0;
        ph_val    = IndexReload;
        pill_load = 1'b0;
        if (emergncy_stop) begin
            state_d = StFault;
            fault_d = FaultEstop;
        end else if (conveyor_jam && (state_q inside {StIndex, StSettle, StFill, StPause})) begin
            state_d = StFault;
            fault_d = FaultJam;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StIndex;
                        ph_load = 1'b1;
                    end
                end
                StIndex: begin
                    if (ph_zero) begin
                        state_d = StSettle;
                        ph_load = 1'b1;
                        ph_val  = SettleReload;
                    end
                end
                StSettle: begin
                    if (ph_zero) begin
                        state_d   = StFill;
                        pill_load = 1'b1;
                    end
                end
                StFill: begin
                    if (bottle_full) begin
                        state_d = batch_done ? StFinish : StIndex;
                        ph_load = !batch_done;
                    end else if (hopper_empty) begin
                        // Phase timer doubles as the refill watchdog while paused.
                        state_d = StPause;
                        ph_load = 1'b1;
                        ph_val  = RefillReload;
                    end else if (pill_zero) begin
                        tick_d    = 1'b1;
                        pill_load = 1'b1;
                    end
                end
                StPause: begin
                    if (hopper_refill && !hopper_empty) begin
                        state_d   = StFill;
                        pill_load = 1'b1;
                    end
`ifdef FILL_WATCHDOG_EN
                    else if (ph_zero) begin
                        state_d = StFault;
                        fault_d = FaultRefillTo;
                    end
`endif
                end
                StFinish: begin
                    if (ack) begin
                        state_d = StIdle;
                    end
                end
                StFault: begin
                    if (ack && !conveyor_jam) begin
                        state_d = StIdle;
                        fault_d = FaultNone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state_q     <= StIdle;
            fault_q     <= FaultNone;
            alarm_cnt_q <= '0;
            conveyor_q  <= 1'b0;
            gate_q      <= 1'b0;
            tick_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            alarm_cnt_q <= alarm_cnt_d;
            conveyor_q  <= (state_d == StIndex);
            gate_q      <= (state_d == StFill);
            tick_q      <= tick_d;
            alarm_q     <= (state_d == StFault) && alarm_cnt_d[AlarmBit];
        end
    end

    assign conveyor_on = conveyor_q;
    assign gate_open   = gate_q;
    assign pill_tick   = tick_q;
    assign alarm       = alarm_q;
    assign state_out   = state_q;
    assign fault_code  = fault_q;

endmodule

// File: tb/tb_fill_line_sequencer.sv
// Self-checking bench for fill_line_sequencer: vector table, directed corners, random vs model.
module tb_fill_line_sequencer;

    localparam int PP = 4;
    localparam int IC = 5;
    localparam int SC = 2;
    localparam int RT = 8;

    localparam logic [7:0] I_NONE   = 8'h00;
    localparam logic [7:0] I_START  = 8'h80;
    localparam logic [7:0] I_BFULL  = 8'h40;
    localparam logic [7:0] I_BDONE  = 8'h20;
    localparam logic [7:0] I_ESTOP  = 8'h10;
    localparam logic [7:0] I_EMPTY  = 8'h08;
    localparam logic [7:0] I_REFILL = 8'h04;
    localparam logic [7:0] I_JAM    = 8'h02;
    localparam logic [7:0] I_ACK    = 8'h01;

    localparam int S_IDLE = 0, S_INDEX = 1, S_SETTLE = 2, S_FILL = 3;
    localparam int S_PAUSE = 4, S_FINISH = 5, S_FAULT = 6;

    typedef struct packed {
        logic start, bottle_full, batch_done, estop, empty, refill, jam, ack;
    } in_t;

    typedef struct {
        logic [7:0] in;
        int         st;
        bit         conv, gate, tick;
    } vec_t;

    logic clk_1khz = 1'b0;
    logic switch_clr = 1'b0;
    logic start = 1'b0, bottle_full = 1'b0, batch_done = 1'b0, emergncy_stop = 1'b0;
    logic hopper_empty = 1'b0, hopper_refill = 1'b0, conveyor_jam = 1'b0, ack = 1'b0;
    logic conveyor_on, gate_open, pill_tick, alarm;
    logic [2:0] state_out;
    logic [1:0] fault_code;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time spent in the current state and since the last pill.
    int m_state = 0, m_code = 0, m_t = 0, m_p = 0, m_cnt = 0;
    bit m_tick = 0;

    vec_t tbl[$];

    always #5 clk_1khz = ~clk_1khz;

    fill_line_sequencer #(
        .PILL_PERIOD    (PP),
        .INDEX_CYCLES   (IC),
        .SETTLE_CYCLES  (SC),
        .REFILL_TIMEOUT (RT)
    ) dut (
        .clk_1khz      (clk_1khz),
        .switch_clr    (switch_clr),
        .start         (start),
        .bottle_full   (bottle_full),
        .batch_done    (batch_done),
        .emergncy_stop (emergncy_stop),
        .hopper_empty  (hopper_empty),
        .hopper_refill (hopper_refill),
        .conveyor_jam  (conveyor_jam),
        .ack           (ack),
        .conveyor_on   (conveyor_on),
        .gate_open     (gate_open),
        .pill_tick     (pill_tick),
        .alarm         (alarm),
        .state_out     (state_out),
        .fault_code    (fault_code)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_code = 0; m_t = 0; m_p = 0; m_cnt = 0; m_tick = 0;
    endtask

    task automatic model_step(input in_t in);
        int ns;
        ns     = m_state;
        m_tick = 0;
        m_cnt  = (m_cnt + 1) % 512;
        m_t++;
        if (m_state == S_FILL) m_p++;
        if (in.estop) begin
            ns = S_FAULT; m_code = 1;
        end else if (in.jam && m_state >= S_INDEX && m_state <= S_PAUSE) begin
            ns = S_FAULT; m_code = 2;
        end else begin
            case (m_state)
                S_IDLE:   if (in.start) ns = S_INDEX;
                S_INDEX:  if (m_t == IC) ns = S_SETTLE;
                S_SETTLE: if (m_t == SC) ns = S_FILL;
                S_FILL: begin
                    if (in.bottle_full) ns = in.batch_done ? S_FINISH : S_INDEX;
                    else if (in.empty) ns = S_PAUSE;
                    else if (m_p == PP) begin m_tick = 1; m_p = 0; end
                end
                S_PAUSE: begin
                    if (in.refill && !in.empty) ns = S_FILL;
`ifdef FILL_WATCHDOG_EN
                    else if (m_t == RT) begin ns = S_FAULT; m_code = 3; end
`endif
                end
                S_FINISH: if (in.ack) ns = S_IDLE;
                S_FAULT:  if (in.ack && !in.jam) begin ns = S_IDLE; m_code = 0; end
                default:  ns = S_IDLE;
            endcase
        end
        if (ns != m_state) begin m_t = 0; m_p = 0; end
        m_state = ns;
    endtask

    task automatic drive(input in_t in);
        start = in.start; bottle_full = in.bottle_full; batch_done = in.batch_done;
        emergncy_stop = in.estop; hopper_empty = in.empty; hopper_refill = in.refill;
        conveyor_jam = in.jam; ack = in.ack;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic [7:0] bits);
        drive(in_t'(bits));
        @(posedge clk_1khz);
        model_step(in_t'(bits));
        @(negedge clk_1khz);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"}, int'(state_out), m_state);
        chk({tag, ".code"}, int'(fault_code), m_code);
        chk({tag, ".conveyor_on"}, int'(conveyor_on), int'(m_state == S_INDEX));
        chk({tag, ".gate_open"}, int'(gate_open), int'(m_state == S_FILL));
        chk({tag, ".pill_tick"}, int'(pill_tick), int'(m_tick));
        chk({tag, ".alarm"}, int'(alarm), int'(m_state == S_FAULT && m_cnt[7]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".state"}, int'(state_out), 0);
        chk({tag, ".code"}, int'(fault_code), 0);
        chk({tag, ".outs"}, int'({conveyor_on, gate_open, pill_tick, alarm}), 0);
    endtask

    task automatic mstep(input logic [7:0] bits, input string tag);
        step(bits);
        check_model(tag);
    endtask

    task automatic goto_fill(input string tag);
        mstep(I_START, tag);
        for (int i = 0; i < 20 && m_state != S_FILL; i++) mstep(I_NONE, tag);
        chk({tag, ".reach_fill"}, int'(state_out), S_FILL);
    endtask

    task automatic add(input logic [7:0] in, input int st, input bit c, input bit g,
                       input bit t, input int n);
        vec_t v;
        v.in = in; v.st = st; v.conv = c; v.gate = g; v.tick = t;
        repeat (n) tbl.push_back(v);
    endtask

    initial begin
        bit saw_hi, saw_lo;
        int ticks_at;
        logic [7:0] rin;
        bit estop_l, jam_l, empty_l;

        // Nominal batch: index, settle, pill cadence, bottle_full suppression, finish.
        add(I_START, 1, 1, 0, 0, 5);
        tbl[0].in = I_START;
        for (int i = 1; i < 5; i++) tbl[i].in = I_NONE;
        add(I_NONE, 2, 0, 0, 0, 2);
        add(I_NONE, 3, 0, 1, 0, 4);
        add(I_NONE, 3, 0, 1, 1, 1);
        add(I_NONE, 3, 0, 1, 0, 3);
        add(I_NONE, 3, 0, 1, 1, 1);
        add(I_NONE, 3, 0, 1, 0, 3);
        add(I_BFULL, 1, 1, 0, 0, 1);
        add(I_NONE, 1, 1, 0, 0, 4);
        add(I_NONE, 2, 0, 0, 0, 2);
        add(I_NONE, 3, 0, 1, 0, 3);
        add(I_BFULL | I_BDONE, 5, 0, 0, 0, 1);
        add(I_START, 5, 0, 0, 0, 1);
        add(I_ACK, 0, 0, 0, 0, 1);
        add(I_BFULL, 0, 0, 0, 0, 1);

        #3;
        check_zero("reset");
        @(negedge clk_1khz);
        switch_clr = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            step(tbl[i].in);
            chk($sformatf("vec%0d.state", i), int'(state_out), tbl[i].st);
            chk($sformatf("vec%0d.outs", i), int'({conveyor_on, gate_open, pill_tick}),
                int'({tbl[i].conv, tbl[i].gate, tbl[i].tick}));
        end

        // Hopper empties mid-fill, refill while still empty is ignored.
        goto_fill("pause");
        mstep(I_NONE, "pause");
        mstep(I_EMPTY, "pause");
        chk("pause.entered", int'(state_out), S_PAUSE);
        chk("pause.gate", int'(gate_open), 0);
        mstep(I_EMPTY | I_REFILL, "pause");
        chk("pause.refill_ignored", int'(state_out), S_PAUSE);
        mstep(I_NONE, "pause");
        mstep(I_REFILL, "pause");
        chk("pause.resumed", int'(state_out), S_FILL);
        ticks_at = -1;
        for (int i = 1; i <= 10 && ticks_at < 0; i++) begin
            mstep(I_NONE, "pause");
            if (pill_tick) ticks_at = i;
        end
        chk("pause.tick_delay", ticks_at, PP);
        mstep(I_BFULL | I_BDONE, "pause");
        mstep(I_ACK, "pause");

        // Emergency stop: alarm blinks, ack ignored until stop released.
        goto_fill("estop");
        mstep(I_ESTOP, "estop");
        chk("estop.code", int'(fault_code), 1);
        saw_hi = 0; saw_lo = 0;
        for (int i = 0; i < 300; i++) begin
            mstep((i % 50 == 7) ? (I_ESTOP | I_ACK) : I_ESTOP, "estop");
            if (alarm) saw_hi = 1; else saw_lo = 1;
        end
        chk("estop.alarm_toggles", int'(saw_hi && saw_lo), 1);
        chk("estop.ack_ignored", int'(state_out), S_FAULT);
        mstep(I_NONE, "estop");
        mstep(I_ACK, "estop");
        chk("estop.exit_state", int'(state_out), S_IDLE);
        chk("estop.exit_code", int'(fault_code), 0);

        // Jam during index.
        mstep(I_START, "jam");
        mstep(I_NONE, "jam");
        mstep(I_JAM, "jam");
        chk("jam.code", int'(fault_code), 2);
        chk("jam.conveyor", int'(conveyor_on), 0);
        mstep(I_JAM | I_ACK, "jam");
        chk("jam.ack_ignored", int'(state_out), S_FAULT);
        mstep(I_ACK, "jam");
        chk("jam.exit", int'(state_out), S_IDLE);

        // Long pause: watchdog faults out, otherwise the line keeps waiting.
        goto_fill("wdog");
        mstep(I_EMPTY, "wdog");
        for (int i = 1; i < RT; i++) mstep(I_EMPTY, "wdog");
        chk("wdog.before", int'(state_out), S_PAUSE);
        mstep(I_EMPTY, "wdog");
`ifdef FILL_WATCHDOG_EN
        chk("wdog.state", int'(state_out), S_FAULT);
        chk("wdog.code", int'(fault_code), 3);
`else
        for (int i = 0; i < 20; i++) mstep(I_EMPTY, "wdog");
        chk("wdog.waits", int'(state_out), S_PAUSE);
`endif
        mstep(I_ESTOP, "wdog");
        mstep(I_ACK, "wdog");

        // Asynchronous clear mid-fill.
        goto_fill("clr");
        mstep(I_NONE, "clr");
        #2;
        switch_clr = 1'b0;
        #1;
        check_zero("clr.async");
        model_reset();
        @(negedge clk_1khz);
        switch_clr = 1'b1;
        for (int i = 0; i < 3; i++) mstep(I_NONE, "clr.idle");
        mstep(I_START, "clr.start");
        chk("clr.restart", int'(state_out), S_INDEX);

        // Randomised traffic against the model.
        estop_l = 0; jam_l = 0; empty_l = 0;
        for (int i = 0; i < 4000; i++) begin
            if (estop_l ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0))
                estop_l = ~estop_l;
            if (jam_l ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0))
                jam_l = ~jam_l;
            if ($urandom_range(0, 29) == 0) empty_l = ~empty_l;
            rin = I_NONE;
            if ($urandom_range(0, 9) == 0) rin |= I_START;
            if ($urandom_range(0, 14) == 0) rin |= I_BFULL;
            if ($urandom_range(0, 1) == 0) rin |= I_BDONE;
            if ($urandom_range(0, 7) == 0) rin |= I_REFILL;
            if ($urandom_range(0, 9) == 0) rin |= I_ACK;
            if (estop_l) rin |= I_ESTOP;
            if (jam_l) rin |= I_JAM;
            if (empty_l) rin |= I_EMPTY;
            mstep(rin, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
